// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_stage_pkg
// Purpose  : Types and constants shared by the MEM pipeline stage and its
//            MEM/WB pipeline register.
//            - state_e          : MEM-stage FSM state encoding
//            - CTRL_*           : bit positions inside the 4-bit ex_ctrl bundle
//            - TIMEOUT_DEFAULT  : default dmem_ack wait limit in ACCESS cycles
//            - is_word_aligned  : helper for the word-alignment test
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   // Explicit 1-bit encoding: IDLE must be the all-zero reset value.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   // ex_ctrl = {MemRead, MemWrite, MemToReg, RegWrite}, MSB first.
   localparam int unsigned CTRL_MEM_READ   = 3;
   localparam int unsigned CTRL_MEM_WRITE  = 2;
   localparam int unsigned CTRL_MEM_TO_REG = 1;
   localparam int unsigned CTRL_REG_WRITE  = 0;

   localparam int unsigned CTRL_W     = 4;
   localparam int unsigned REG_ADDR_W = 5;

   localparam int TIMEOUT_DEFAULT = 15;

   // Only word accesses are supported, so the two LSBs must be zero.
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline register. A bubble insert clears the valid and
//            register-write fields (the data fields hold); otherwise a load
//            enable captures every field. Bubble has priority over load.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            load_en, bubble     - capture new fields / insert a bubble
//            in_*                - next MEM/WB field values
//            wb_*                - registered MEM/WB fields
//            wb_fwd_data         - value the writeback stage will produce
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              bubble,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [4:0]        in_reg_dest,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_mem_data,
   output logic [4:0]        wb_reg_dest,
   output logic [DATA_W-1:0] wb_fwd_data
);

   logic              valid_q,      valid_d;
   logic              reg_write_q,  reg_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [DATA_W-1:0] mem_data_q,   mem_data_d;
   logic [4:0]        reg_dest_q,   reg_dest_d;

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      alu_result_d = alu_result_q;
      mem_data_d   = mem_data_q;
      reg_dest_d   = reg_dest_q;
      if (bubble) begin
         // A bubble only needs to be harmless to WB: no valid, no write.
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (load_en) begin
         valid_d      = in_valid;
         reg_write_d  = in_reg_write;
         mem_to_reg_d = in_mem_to_reg;
         alu_result_d = in_alu_result;
         mem_data_d   = in_mem_data;
         reg_dest_d   = in_reg_dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_result_q <= '0;
         mem_data_q   <= '0;
         reg_dest_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_result_q <= alu_result_d;
         mem_data_q   <= mem_data_d;
         reg_dest_q   <= reg_dest_d;
      end
   end

   assign wb_valid      = valid_q;
   assign wb_reg_write  = reg_write_q;
   assign wb_mem_to_reg = mem_to_reg_q;
   assign wb_alu_result = alu_result_q;
   assign wb_mem_data   = mem_data_q;
   assign wb_reg_dest   = reg_dest_q;
   assign wb_fwd_data   = mem_to_reg_q ? mem_data_q : alu_result_q;

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Non-memory ops pass to MEM/WB in one cycle.
//            Aligned loads/stores stall the pipe for one IDLE request cycle,
//            then hold a registered request in ACCESS until dmem_ack or until
//            TIMEOUT ACCESS cycles pass without it (bus error). Misaligned
//            memory ops complete at once with a misalignment error.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            ex_*                - EX/MEM inputs (held by upstream on stall)
//            mem_stall           - combinational hold for EX and earlier
//            dmem_*              - registered data-memory request, rdata/ack in
//            wb_*                - MEM/WB register fields and forwarding value
//            misalign_err        - one-cycle pulse, aligned with the MEM/WB
//                                  write of the misaligned op
//            bus_err             - one-cycle pulse, aligned with the MEM/WB
//                                  write of the timed-out op
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [4:0]        ex_reg_dest,
   input  logic [3:0]        ex_ctrl,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_mem_data,
   output logic [4:0]        wb_reg_dest,
   output logic [DATA_W-1:0] wb_fwd_data,
   output logic              misalign_err,
   output logic              bus_err
);

   // The counter holds the number of ACCESS cycles already spent without an
   // ack; it never has to represent more than TIMEOUT-1.
   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dmem_req_q,     dmem_req_d;
   logic              dmem_we_q,      dmem_we_d;
   logic [DATA_W-1:0] dmem_addr_q,    dmem_addr_d;
   logic [DATA_W-1:0] dmem_wdata_q,   dmem_wdata_d;
   logic              misalign_err_q, misalign_err_d;
   logic              bus_err_q,      bus_err_d;

   logic              mem_op;
   logic              aligned;
   logic              timeout;
   logic              stall_raw;
   logic              wb_load;
   logic              wb_in_reg_write;
   logic [DATA_W-1:0] wb_in_mem_data;

   // Decode. MemRead+MemWrite together is a write because we follows MemWrite.
   assign mem_op  = ex_valid & (ex_ctrl[CTRL_MEM_READ] | ex_ctrl[CTRL_MEM_WRITE]);
   assign aligned = is_word_aligned(ex_result[1:0]);

   // This ACCESS cycle is the TIMEOUT-th one without ack. An ack in the same
   // cycle takes precedence, hence the !dmem_ack term.
   assign timeout = (state_q == ST_ACCESS) & ~dmem_ack & (cnt_q == CNT_LAST);

   // ------------------------------------------------------------------------
   // State register (all stage flops)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         misalign_err_q <= 1'b0;
         bus_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         misalign_err_q <= misalign_err_d;
         bus_err_q      <= bus_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_op && aligned) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (dmem_ack || timeout) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      stall_raw       = 1'b0;
      wb_load         = 1'b0;
      wb_in_reg_write = ex_valid & ex_ctrl[CTRL_REG_WRITE];
      wb_in_mem_data  = '0;
      cnt_d           = cnt_q;
      dmem_req_d      = dmem_req_q;
      dmem_we_d       = dmem_we_q;
      dmem_addr_d     = dmem_addr_q;
      dmem_wdata_d    = dmem_wdata_q;
      misalign_err_d  = 1'b0;
      bus_err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_op && aligned) begin
               // Request cycle: stall now, launch the registered request.
               stall_raw    = 1'b1;
               dmem_req_d   = 1'b1;
               dmem_we_d    = ex_ctrl[CTRL_MEM_WRITE];
               dmem_addr_d  = ex_result;
               dmem_wdata_d = ex_store_data;
               cnt_d        = '0;
            end else begin
               // Non-memory op, bubble or misaligned op: straight to MEM/WB.
               // Any dmem_ack seen here is stale and deliberately ignored.
               wb_load = 1'b1;
               if (mem_op) begin
                  misalign_err_d  = 1'b1;
                  wb_in_reg_write = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               wb_load    = 1'b1;
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               if (!dmem_we_q) begin
                  wb_in_mem_data = dmem_rdata;
               end
            end else if (timeout) begin
               // Abort: retire the op without a register write.
               wb_load         = 1'b1;
               wb_in_reg_write = 1'b0;
               bus_err_d       = 1'b1;
               dmem_req_d      = 1'b0;
               dmem_we_d       = 1'b0;
            end else begin
               stall_raw = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            stall_raw = 1'b0;
         end
      endcase
   end

   // The IDLE stall term depends on live ex_* inputs, so it is masked while
   // reset is asserted to keep the pipe free to flush.
   assign mem_stall = stall_raw & rst_n;

   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign misalign_err = misalign_err_q;
   assign bus_err      = bus_err_q;

   // ------------------------------------------------------------------------
   // MEM/WB pipeline register
   // ------------------------------------------------------------------------
   mem_wb_reg #(
      .DATA_W (DATA_W)
   ) u_mem_wb_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_en       (wb_load),
      .bubble        (stall_raw),
      .in_valid      (ex_valid),
      .in_reg_write  (wb_in_reg_write),
      .in_mem_to_reg (ex_ctrl[CTRL_MEM_TO_REG]),
      .in_alu_result (ex_result),
      .in_mem_data   (wb_in_mem_data),
      .in_reg_dest   (ex_reg_dest),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_alu_result (wb_alu_result),
      .wb_mem_data   (wb_mem_data),
      .wb_reg_dest   (wb_reg_dest),
      .wb_fwd_data   (wb_fwd_data)
   );

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Each instruction is turned
//            into per-cycle expectations by a transaction-level model
//            (request cycle, ACCESS cycles until ack or timeout, result one
//            cycle after completion); a single compare process checks the DUT
//            against them on every falling edge. Directed cases pin the model
//            with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_valid;
   logic [31:0]       ex_result;
   logic [31:0]       ex_store_data;
   logic [4:0]        ex_reg_dest;
   logic [3:0]        ex_ctrl;
   logic              mem_stall;
   logic              dmem_req;
   logic              dmem_we;
   logic [31:0]       dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ack;
   logic              wb_valid;
   logic              wb_reg_write;
   logic              wb_mem_to_reg;
   logic [31:0]       wb_alu_result;
   logic [31:0]       wb_mem_data;
   logic [4:0]        wb_reg_dest;
   logic [31:0]       wb_fwd_data;
   logic              misalign_err;
   logic              bus_err;

   mem_stage #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_result     (ex_result),
      .ex_store_data (ex_store_data),
      .ex_reg_dest   (ex_reg_dest),
      .ex_ctrl       (ex_ctrl),
      .mem_stall     (mem_stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_alu_result (wb_alu_result),
      .wb_mem_data   (wb_mem_data),
      .wb_reg_dest   (wb_reg_dest),
      .wb_fwd_data   (wb_fwd_data),
      .misalign_err  (misalign_err),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          valid;
      logic [3:0]  ctrl;
      logic [31:0] result;
      logic [31:0] sdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
   } op_t;

   // Expected stall / request side for one cycle.
   typedef struct {
      bit          stall;
      bit          req;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_c_t;

   // Expected MEM/WB contents for one cycle: kind 0 bubble, 1 data, 2 error.
   typedef struct {
      int          kind;
      bit          reg_write;
      bit          mem_to_reg;
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [4:0]  rd;
      bit          merr;
      bit          berr;
   } exp_w_t;

   exp_c_t ce[int];
   exp_w_t ew[int];

   int n_tests   = 0;
   int n_fail    = 0;
   bit model_on  = 0;
   int stall_cnt = 0;
   int req_cnt   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Compare process
   // ------------------------------------------------------------------------
   initial begin
      exp_c_t e;
      exp_w_t w;
      logic [31:0] fwd;
      forever begin
         @(negedge clk);
         if (model_on) begin
            if (mem_stall === 1'b1) stall_cnt++;
            if (dmem_req === 1'b1) req_cnt++;
            if (ce.exists(cyc)) begin
               e = ce[cyc];
               check("mem_stall", 32'(mem_stall), 32'(e.stall));
               check("dmem_req", 32'(dmem_req), 32'(e.req));
               if (e.req) begin
                  check("dmem_we", 32'(dmem_we), 32'(e.we));
                  check("dmem_addr", dmem_addr, e.addr);
                  check("dmem_wdata", dmem_wdata, e.wdata);
               end
            end
            if (ew.exists(cyc)) begin
               w = ew[cyc];
               check("wb_valid", 32'(wb_valid), 32'(w.kind != 0));
               check("wb_reg_write", 32'(wb_reg_write), 32'((w.kind == 1) && w.reg_write));
               if (w.kind == 1) begin
                  fwd = w.mem_to_reg ? w.mdata : w.alu;
                  check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(w.mem_to_reg));
                  check("wb_alu_result", wb_alu_result, w.alu);
                  check("wb_mem_data", wb_mem_data, w.mdata);
                  check("wb_reg_dest", 32'(wb_reg_dest), 32'(w.rd));
                  check("wb_fwd_data", wb_fwd_data, fwd);
               end
               check("misalign_err", 32'(misalign_err), 32'(w.merr));
               check("bus_err", 32'(bus_err), 32'(w.berr));
            end
         end
      end
   end

   function automatic op_t mk(input bit v, input logic [3:0] ctrl, input logic [31:0] res,
                              input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata);
      op_t o;
      o.valid = v; o.ctrl = ctrl; o.result = res; o.sdata = sd; o.rd = rd; o.rdata = rdata;
      return o;
   endfunction

   // Drives one instruction for as many cycles as it occupies the stage and
   // schedules what the outputs must be. ack_at is the ACCESS cycle (1-based)
   // in which memory acks; outside 1..TIMEOUT means it never acks in time.
   task automatic do_op(input op_t op, input int ack_at);
      bit is_mem, is_wr, mis, acked;
      int last, c;
      exp_c_t e;
      exp_w_t w;
      is_mem = op.valid && (op.ctrl[3] || op.ctrl[2]);
      is_wr  = op.ctrl[2];
      mis    = is_mem && (op.result[1:0] != 2'b00);
      acked  = 0;
      if (!is_mem || mis) last = 0;
      else if (ack_at >= 1 && ack_at <= TIMEOUT) begin last = ack_at; acked = 1; end
      else last = TIMEOUT;
      for (int k = 0; k <= last; k++) begin
         @(posedge clk); #1;
         c = cyc;
         ex_valid      = op.valid;
         ex_ctrl       = op.ctrl;
         ex_result     = op.result;
         ex_store_data = op.sdata;
         ex_reg_dest   = op.rd;
         dmem_rdata    = $urandom;
         if (k == 0) dmem_ack = ($urandom_range(0, 3) == 0);   // stale ack while idle
         else if (acked && k == last) begin dmem_ack = 1'b1; dmem_rdata = op.rdata; end
         else dmem_ack = 1'b0;
         e.stall = (k < last);
         e.req   = (k >= 1);
         e.we    = is_wr;
         e.addr  = op.result;
         e.wdata = op.sdata;
         ce[c] = e;
         w = '{default: 0};
         if (k < last || !op.valid) w.kind = 0;
         else if (mis || (is_mem && !acked)) begin
            w.kind = 2; w.merr = mis; w.berr = !mis;
         end else begin
            w.kind       = 1;
            w.reg_write  = op.ctrl[0];
            w.mem_to_reg = op.ctrl[1];
            w.alu        = op.result;
            w.mdata      = (is_mem && !is_wr) ? op.rdata : 32'h0;
            w.rd         = op.rd;
         end
         ew[c + 1] = w;
      end
   endtask

   task automatic step_idle();
      do_op(mk(0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      op_t o;
      int  sel, ack_at;

      // Reset with an aligned load presented: nothing may stall or request.
      rst_n = 1'b0; ex_valid = 1'b1; ex_ctrl = 4'b1011; ex_result = 32'h100;
      ex_store_data = 32'h0; ex_reg_dest = 5'd3; dmem_rdata = 32'h0; dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_stall", 32'(mem_stall), 32'h0);
      check("rst_dmem_req", 32'(dmem_req), 32'h0);
      check("rst_wb_valid", 32'(wb_valid), 32'h0);
      check("rst_wb_alu_result", wb_alu_result, 32'h0);
      check("rst_errs", 32'({misalign_err, bus_err}), 32'h0);
      ex_valid = 1'b0;
      rst_n = 1'b1;
      model_on = 1'b1;

      // ADD 0x10 -> rd 5, no stall.
      stall_cnt = 0;
      do_op(mk(1, 4'b0001, 32'h0000_0010, 32'h0, 5'd5, 32'h0), 0);
      step_idle();
      check("add_wb_valid", 32'(wb_valid), 32'h1);
      check("add_wb_alu", wb_alu_result, 32'h10);
      check("add_wb_rd", 32'(wb_reg_dest), 32'd5);
      check("add_no_stall", stall_cnt, 0);

      // Load 0x100, ack three cycles after request.
      stall_cnt = 0;
      do_op(mk(1, 4'b1011, 32'h100, 32'h0, 5'd7, 32'hDEAD_BEEF), 4);
      step_idle();
      check("ld_stall_cycles", stall_cnt, 4);
      check("ld_wb_mem_data", wb_mem_data, 32'hDEAD_BEEF);
      check("ld_wb_fwd_data", wb_fwd_data, 32'hDEAD_BEEF);

      // Store 0x1234 to 0x104.
      do_op(mk(1, 4'b0100, 32'h104, 32'h1234, 5'd0, 32'h0), 2);
      check("st_dmem_we", 32'(dmem_we), 32'h1);
      check("st_dmem_wdata", dmem_wdata, 32'h1234);
      step_idle();
      check("st_wb_reg_write", 32'(wb_reg_write), 32'h0);

      // Misaligned load at 0x102.
      stall_cnt = 0; req_cnt = 0;
      do_op(mk(1, 4'b1011, 32'h102, 32'h0, 5'd8, 32'h0), 1);
      step_idle();
      check("mis_err_pulse", 32'(misalign_err), 32'h1);
      check("mis_no_req", req_cnt, 0);
      check("mis_no_stall", stall_cnt, 0);
      step_idle();
      check("mis_err_one_cycle", 32'(misalign_err), 32'h0);

      // Load that never gets an ack, then the same load acked on the last cycle.
      req_cnt = 0;
      do_op(mk(1, 4'b1011, 32'h200, 32'h0, 5'd9, 32'h5555_AAAA), 0);
      step_idle();
      check("to_req_cycles", req_cnt, TIMEOUT);
      check("to_bus_err", 32'(bus_err), 32'h1);
      check("to_wb_reg_write", 32'(wb_reg_write), 32'h0);
      req_cnt = 0;
      do_op(mk(1, 4'b1011, 32'h200, 32'h0, 5'd9, 32'h5555_AAAA), TIMEOUT);
      step_idle();
      check("ackwin_req_cycles", req_cnt, TIMEOUT);
      check("ackwin_bus_err", 32'(bus_err), 32'h0);
      check("ackwin_wb_mem_data", wb_mem_data, 32'h5555_AAAA);

      // Randomised instruction stream.
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 99);
         o = mk(sel >= 10, 4'($urandom_range(0, 15)), $urandom, $urandom,
                5'($urandom_range(0, 31)), $urandom);
         if (sel >= 10 && sel < 40) o.ctrl[3:2] = 2'b00;
         else if (sel >= 40 && sel < 85) begin
            o.ctrl[3:2] = 2'($urandom_range(1, 3));
            o.result    = o.result & 32'hFFFF_FFFC;
         end else if (sel >= 85) begin
            o.ctrl[3:2] = 2'($urandom_range(1, 3));
            o.result    = (o.result & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
         end
         case ($urandom_range(0, 9))
            6:       ack_at = TIMEOUT;
            7:       ack_at = TIMEOUT - 1;
            8:       ack_at = 0;
            9:       ack_at = TIMEOUT + 1;
            default: ack_at = $urandom_range(1, 5);
         endcase
         do_op(o, ack_at);
      end

      // Reset in the middle of ACCESS, with a previous result in MEM/WB.
      do_op(mk(1, 4'b0001, 32'h0000_ABCD, 32'h0, 5'd9, 32'h0), 0);
      step_idle();
      model_on = 1'b0;
      check("pre_rst_wb_alu", wb_alu_result, 32'h0000_ABCD);
      ex_valid = 1'b1; ex_ctrl = 4'b1011; ex_result = 32'h300; ex_reg_dest = 5'd4;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_dmem_req", 32'(dmem_req), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_dmem_req", 32'(dmem_req), 32'h0);
      check("mid_rst_dmem_addr", dmem_addr, 32'h0);
      check("mid_rst_mem_stall", 32'(mem_stall), 32'h0);
      check("mid_rst_wb_valid", 32'(wb_valid), 32'h0);
      check("mid_rst_wb_alu", wb_alu_result, 32'h0);
      check("mid_rst_wb_rd", 32'(wb_reg_dest), 32'h0);
      check("mid_rst_wb_fwd", wb_fwd_data, 32'h0);
      @(negedge clk);
      ex_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_on = 1'b1;

      // Pipe must work normally again after the reset.
      do_op(mk(1, 4'b1011, 32'h400, 32'h0, 5'd11, 32'hCAFE_F00D), 2);
      step_idle();
      check("post_rst_wb_mem_data", wb_mem_data, 32'hCAFE_F00D);
      step_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_stage
`default_nettype wire
